add_share_sched: RTL
====================

// Module: add_share_sched
// PURPOSE
//  Shares one pipelined 32-bit adder among NUM_REQ requesters.
//  - Grants requesters round-robin and issues their operands to the adder.
//  - Tracks the requester ID of each in-flight operation.
//  - Returns each sum, tagged with its requester ID.
//  - Drain/halt control lets software quiesce the adder cleanly.
//  - Sits between the requester blocks and the add datapath (a, b -> sum).
// PARAMETERS
//  NUM_REQ  4   requesters, 2..8
//  DATA_W   32  operand width; sum is DATA_W+1
//  ADD_LAT  1   adder latency from add_valid to add_sum valid, in cycles, 1..8
// PORTS
//  clk        in   1               clock; all logic on posedge clk
//  reset      in   1               async, active-high reset
//  req_valid  in   NUM_REQ         per-requester operand valid
//  req_ready  out  NUM_REQ         per-requester accept, one-hot or zero
//  req_a      in   NUM_REQ*DATA_W  operand a; requester i in slice i
//  req_b      in   NUM_REQ*DATA_W  operand b; requester i in slice i
//  halt       in   1               stop accepting requests and drain
//  add_valid  out  1               operands on add_a/add_b valid this cycle
//  add_a      out  DATA_W          operand a to shared adder
//  add_b      out  DATA_W          operand b to shared adder
//  add_sum    in   DATA_W+1        adder result, valid ADD_LAT cycles after add_valid
//  rsp_valid  out  1               response pulse; no backpressure
//  rsp_id     out  ID_W            requester ID of the response; ID_W=$clog2(NUM_REQ)
//  rsp_sum    out  DATA_W+1        sum returned with the response
//  busy       out  1               any operation in flight or response pending
//  halted     out  1               state == HALTED
// BEHAVIOUR
//  Reset:
//   - add_valid, rsp_valid, busy, halted, add_a, add_b, rsp_id, rsp_sum all 0.
//   - RR pointer = NUM_REQ-1, so requester 0 wins first.
//   - State = RUN.
//  Arbitration:
//   - Grant goes to the first requester with req_valid set, scanning from pointer+1 mod NUM_REQ.
//   - req_ready[i] = grant[i] && state==RUN && !halt. It is combinational from registered state and the inputs.
//   - Handshake: req_valid[i] && req_ready[i] in cycle T.
//   - On handshake, pointer <= i.
//   - If no handshake occurs, the pointer holds.
//  Pipeline:
//   - Accept in cycle T -> add_valid/add_a/add_b registered at T+1.
//   - add_sum is sampled at T+1+ADD_LAT.
//   - rsp_valid/rsp_id/rsp_sum are registered at T+2+ADD_LAT.
//   - Throughput is one operation per cycle.
//   - Responses return in issue order.
//   - ID tags travel in an ADD_LAT-deep valid+ID shift register.
//   - add_a/add_b hold their last value when add_valid=0.
//  Arithmetic:
//   - The block does no arithmetic.
//   - add_sum is passed through unmodified, full DATA_W+1 bits, so carry-out is preserved.
//  FSM (add_arb_state_t):
//   - RUN: halt=1 -> DRAIN.
//   - DRAIN: busy=0 -> HALTED; halt=0 -> RUN. The busy=0 transition takes priority.
//   - HALTED: halt=0 -> RUN.
//   - No request is accepted in a cycle where halt=1, in any state.
//  Boundaries:
//   - halt rises in the same cycle as req_valid: no accept.
//   - A single active requester is granted back-to-back every cycle.
//   - Pointer wraps NUM_REQ-1 -> 0.
//   - Reset mid-operation drops all in-flight tags; no responses are produced for them.
// CONFIGURATION
//  ADD_SHARE_GNT_CNT_EN defined:
//   - Adds ports cnt_sel in ID_W and cnt_val out 16.
//   - One 16-bit saturating accept counter per requester.
//   - cnt_val = counter[cnt_sel], combinational.
//   - Counters reset to 0.
//  ADD_SHARE_GNT_CNT_EN undefined: the ports and counters are absent.
// STRUCTURE
//  Package add_share_pkg:
//   - add_arb_state_t enum {RUN, DRAIN, HALTED}.
//   - MAX_REQ=8, MAX_LAT=8.
//   - Function id_w(n).
//  Sub-module add_rr_arbiter (NUM_REQ):
//   - Inputs: req vector, pointer, enable.
//   - Outputs: one-hot grant and encoded index.
//   - Combinational; the pointer register stays in the parent.
// TESTING
//  1. Reset, then req0 a=5 b=7 at T -> add_valid T+1; add_sum=12 at T+2; rsp_valid T+3, id=0, sum=12.
//  2. All 4 req_valid held 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_id sequence matches grant order.
//  3. a=32'hFFFF_FFFF b=1 -> rsp_sum=33'h1_0000_0000.
//  4. 3 ops in flight, assert halt -> req_ready=0 immediately; 3 responses; halted=1 one cycle after busy=0. Drop halt -> RUN.
//  5. Assert reset with 2 ops in flight -> outputs 0 at once; no rsp_valid after release; first grant goes to req0.
//  6. ADD_SHARE_GNT_CNT_EN defined: 5 accepts by req2 -> cnt_sel=2 gives cnt_val=5.

Source files
------------

// File: rtl/add_share_pkg.sv
// add_share_pkg: shared types and helpers for the shared-adder scheduler.
//   add_arb_state_t : scheduler run/drain/halted state
//   MAX_REQ/MAX_LAT : supported upper bounds for requester count and adder latency
//   id_w(n)         : width of a requester index for n requesters
package add_share_pkg;

  localparam int MAX_REQ = 8;
  localparam int MAX_LAT = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } add_arb_state_t;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_rr_arbiter.sv
// add_rr_arbiter: combinational round-robin pick among NUM_REQ requesters.
//   req  : request vector
//   ptr  : last granted index; scan starts at ptr+1 and wraps
//   en   : grant enable (gnt forced to zero when low)
//   gnt  : one-hot grant (or zero)
//   idx  : encoded index of the winner (valid whenever any req is set)
module add_rr_arbiter
  import add_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // Offset 1..NUM_REQ from the pointer, so the last winner is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found                            = 1'b1;
        gnt[(int'(ptr) + k) % NUM_REQ]   = en;
        idx                              = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/add_share_sched.sv
// add_share_sched: shares one pipelined adder among NUM_REQ requesters.
// Round-robin grant, operand issue, in-order ID tagging of results, and a
// halt/drain control so software can quiesce the adder.
//   clk, reset            : clock, async active-high reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b           : flat operand buses, requester i in slice i
//   halt                  : stop accepting and drain
//   add_valid/add_a/add_b : operands to the shared adder
//   add_sum               : adder result, ADD_LAT cycles after add_valid
//   rsp_valid/rsp_id/rsp_sum : tagged result pulse, no backpressure
//   busy                  : anything in flight or a response pending
//   halted                : scheduler is in HALTED
// Optional build macro ADD_SHARE_GNT_CNT_EN adds per-requester 16-bit
// saturating accept counters read through cnt_sel/cnt_val.
module add_share_sched
  import add_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  parameter  int ADD_LAT = 1,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic                      halt,
  output logic                      add_valid,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W:0]           add_sum,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W:0]           rsp_sum,
  output logic                      busy,
  output logic                      halted
`ifdef ADD_SHARE_GNT_CNT_EN
  ,
  input  logic [ID_W-1:0]           cnt_sel,
  output logic [15:0]               cnt_val
`endif
);

  add_arb_state_t state, state_nxt;

  logic [ID_W-1:0]             ptr;
  logic [ID_W-1:0]             gnt_idx;
  logic [NUM_REQ-1:0]          gnt;
  logic                        arb_en;
  logic                        acc;
  // Stage 0 lines up with add_valid; stage ADD_LAT lines up with add_sum.
  logic [ADD_LAT:0]            vld_pipe;
  logic [ADD_LAT:0][ID_W-1:0]  id_pipe;

  // ---------------- arbitration ----------------
  assign arb_en = (state == RUN) && !halt;

  add_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign acc       = |(req_valid & gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ptr <= ID_W'(NUM_REQ - 1);
    else if (acc) ptr <= gnt_idx;
  end

  // ---------------- issue ----------------
  // Operands hold their last value between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_a <= '0;
      add_b <= '0;
    end else if (acc) begin
      add_a <= req_a[int'(gnt_idx)*DATA_W +: DATA_W];
      add_b <= req_b[int'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  // ---------------- tag pipeline ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= acc;
      id_pipe[0]  <= gnt_idx;
      for (int i = 1; i <= ADD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign add_valid = vld_pipe[0];

  // ---------------- response ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else begin
      rsp_valid <= vld_pipe[ADD_LAT];
      if (vld_pipe[ADD_LAT]) begin
        rsp_id  <= id_pipe[ADD_LAT];
        rsp_sum <= add_sum;
      end
    end
  end

  assign busy = (|vld_pipe) | rsp_valid;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt) state_nxt = DRAIN;
      DRAIN:   if (!busy)     state_nxt = HALTED;
               else if (!halt) state_nxt = RUN;
      HALTED:  if (!halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    halted = (state == HALTED);
  end

`ifdef ADD_SHARE_GNT_CNT_EN
  logic [NUM_REQ-1:0][15:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (acc && (cnt[gnt_idx] != 16'hFFFF)) begin
      cnt[gnt_idx] <= cnt[gnt_idx] + 16'd1;
    end
  end

  assign cnt_val = (int'(cnt_sel) < NUM_REQ) ? cnt[cnt_sel] : 16'd0;
`endif

endmodule
